// File: rtl/bht_predictor_if.sv
// Fetch/execute-side signal bundle for the branch history table.
// master: pipeline side (drives PC, stall and resolved-branch updates).
// slave:  predictor side (returns prediction, index and perf counters).
interface bht_predictor_if #(
    parameter int PC_W   = 32,
    parameter int IDX_W  = 6,
    parameter int PERF_W = 32
);
    logic              stall;
    logic [PC_W-1:0]   pc_IF;
    logic              taken_IF;
    logic [IDX_W-1:0]  index_IF;
    logic              upd_valid;
    logic [IDX_W-1:0]  upd_index;
    logic              upd_taken;
    logic              upd_pred;
    logic [PERF_W-1:0] branch_cnt;
    logic [PERF_W-1:0] mispredict_cnt;

    modport master (
        output stall, pc_IF, upd_valid, upd_index, upd_taken, upd_pred,
        input  taken_IF, index_IF, branch_cnt, mispredict_cnt
    );

    modport slave (
        input  stall, pc_IF, upd_valid, upd_index, upd_taken, upd_pred,
        output taken_IF, index_IF, branch_cnt, mispredict_cnt
    );
endinterface

// File: rtl/bht_predictor.sv
// Branch history table: per-entry saturating counters, optional gshare
// indexing through a global history register, and branch/mispredict
// performance counters. Lookup is combinational; training happens on the
// clock edge when a resolved branch is presented and the pipe is not stalled.
module bht_predictor #(
    parameter int unsigned ENTRIES   = 64,
    parameter int unsigned CTR_W     = 2,
    parameter int unsigned GHR_W     = 0,
    parameter int unsigned PC_W      = 32,
    parameter int unsigned INDEX_LSB = 2,
    parameter int unsigned PERF_W    = 32,
    localparam int unsigned IDX_W    = $clog2(ENTRIES)
) (
    input logic            clk,
    input logic            rst_n,
    bht_predictor_if.slave bus
);
    logic [CTR_W-1:0]  ctr_q [ENTRIES];
    logic [IDX_W-1:0]  hist_idx;
    logic [IDX_W-1:0]  idx;
    logic [PERF_W-1:0] branch_q;
    logic [PERF_W-1:0] mispred_q;
    logic              upd_en;
    logic              unused_pc;

    assign upd_en    = bus.upd_valid & ~bus.stall;
    // Only a slice of the PC feeds the index.
    assign unused_pc = ^bus.pc_IF;

    generate
        if (GHR_W == 0) begin : g_bimodal
            assign hist_idx = '0;
        end else begin : g_gshare
            logic [GHR_W-1:0] ghr_q;

            // Global history: shift in each resolved outcome (oldest bit drops off).
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ghr_q <= '0;
                end else if (upd_en) begin
                    // Truncating {ghr, taken} keeps the low GHR_W bits, which also
                    // covers the single-bit history case without a separate branch.
                    ghr_q <= GHR_W'({ghr_q, bus.upd_taken});
                end
            end

            assign hist_idx = IDX_W'(ghr_q);
        end
    endgenerate

    assign idx          = bus.pc_IF[INDEX_LSB +: IDX_W] ^ hist_idx;
    assign bus.index_IF = idx;
    // No bypass: a same-cycle update is seen only after the edge.
    assign bus.taken_IF = ctr_q[idx][CTR_W-1];

    // Counter table: saturating train of the addressed entry only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= '0;
            end
        end else if (upd_en) begin
            if (bus.upd_taken) begin
                if (ctr_q[bus.upd_index] != '1) begin
                    ctr_q[bus.upd_index] <= ctr_q[bus.upd_index] + CTR_W'(1);
                end
            end else begin
                if (ctr_q[bus.upd_index] != '0) begin
                    ctr_q[bus.upd_index] <= ctr_q[bus.upd_index] - CTR_W'(1);
                end
            end
        end
    end

    // Performance counters: saturate at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_q  <= '0;
            mispred_q <= '0;
        end else if (upd_en) begin
            if (branch_q != '1) begin
                branch_q <= branch_q + PERF_W'(1);
            end
            if ((bus.upd_pred != bus.upd_taken) && (mispred_q != '1)) begin
                mispred_q <= mispred_q + PERF_W'(1);
            end
        end
    end

    assign bus.branch_cnt     = branch_q;
    assign bus.mispredict_cnt = mispred_q;
endmodule
